// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : Parametrised register file with byte enables, optional write
//            bypass, pending-write scoreboard and sequenced bulk clear.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be,
  output logic                       wr_ready,
  input  logic                       pend_set,
  input  logic [ADDR_W-1:0]          pend_addr,
  input  logic                       clr_start,
  output logic                       busy
);

  localparam int                c_DEPTH     = 2 ** ADDR_W;
  localparam int                c_NBYTES    = DATA_W / 8;
  localparam logic [0:0]        c_ST_IDLE   = 1'b0;
  localparam logic [0:0]        c_ST_CLEAR  = 1'b1;
  localparam logic [ADDR_W-1:0] c_LAST      = '1;
  localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] r_pend;
  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [ADDR_W-1:0]  r_cnt;
  logic               w_busy;
  logic               w_clr_en;
  logic               w_wr_acc;
  logic               w_pend_acc;
  logic [DATA_W-1:0]  w_old;
  logic [DATA_W-1:0]  w_merged;

  // Zero-register targets are dropped here so they never reach storage or bypass.
  assign w_wr_acc   = wr_en && !w_busy &&
                      !((ZERO_REG != 0) && (wr_addr == c_ZERO_ADDR));
  assign w_pend_acc = pend_set && !w_busy &&
                      !((ZERO_REG != 0) && (pend_addr == c_ZERO_ADDR));

  assign w_old = r_mem[wr_addr];

  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < c_NBYTES; b++) begin
      if (wr_be[b]) begin
        w_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Bulk-clear FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bulk-clear FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (clr_start)       w_state_nxt = c_ST_CLEAR;
      c_ST_CLEAR: if (r_cnt == c_LAST) w_state_nxt = c_ST_IDLE;
      default:                         w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Bulk-clear FSM: outputs
  always_comb begin
    w_busy   = (r_state == c_ST_CLEAR);
    w_clr_en = (r_state == c_ST_CLEAR);
  end

  // Counter wraps to zero naturally on the final entry, coinciding with IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == c_ST_IDLE && clr_start) begin
      r_cnt <= '0;
    end else if (w_clr_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend <= '0;
    end else if (w_clr_en) begin
      r_mem[r_cnt]  <= '0;
      r_pend[r_cnt] <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_mem[wr_addr]  <= w_merged;
        r_pend[wr_addr] <= 1'b0;
      end
      // Later assignment lets a same-cycle set win over the commit clear.
      if (w_pend_acc) begin
        r_pend[pend_addr] <= 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_hit;
      logic              w_rz;

      assign w_ra  = rd_addr[k*ADDR_W +: ADDR_W];
      assign w_hit = (BYPASS != 0) && w_wr_acc && (wr_addr == w_ra);
      assign w_rz  = (ZERO_REG != 0) && (w_ra == c_ZERO_ADDR);

      assign rd_data[k*DATA_W +: DATA_W] = w_rz  ? '0       :
                                           w_hit ? w_merged : r_mem[w_ra];
      assign rd_pend[k] = !w_rz && r_pend[w_ra];
    end
  endgenerate

  assign busy     = w_busy;
  assign wr_ready = !w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param
// Brief    : Self-checking bench for regfile_param against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_pend;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_be;
  logic              wr_ready;
  logic              pend_set;
  logic [AW-1:0]     pend_addr;
  logic              clr_start;
  logic              busy;
  logic [AW-1:0]     ra [NR];

  assign rd_addr = {ra[1], ra[0]};

  regfile_param #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pend(rd_pend), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_ready(wr_ready), .pend_set(pend_set),
    .pend_addr(pend_addr), .clr_start(clr_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays plus the index of the entry being swept.
  logic [31:0] m_mem  [DEPTH];
  bit          m_pend [DEPTH];
  int          m_sweep = -1;
  int          n_assert = 0;
  int          n_fail = 0;
  int          nb;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic bit m_wr_acc();
    return wr_en && (m_sweep < 0) && (wr_addr != 0);
  endfunction

  function automatic logic [31:0] exp_data(logic [AW-1:0] a);
    if (a == 0) return 32'h0;
    if (m_wr_acc() && wr_addr == a) return merge(m_mem[a], wr_data, wr_be);
    return m_mem[a];
  endfunction

  function automatic logic [31:0] exp_pend(logic [AW-1:0] a);
    return (a == 0) ? 32'h0 : 32'(m_pend[a]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("busy", 32'(busy), 32'(m_sweep >= 0));
    chk("wr_ready", 32'(wr_ready), 32'(m_sweep < 0));
    for (int k = 0; k < NR; k++) begin
      chk("rd_data", rd_data[k*DW +: DW], exp_data(ra[k]));
      chk("rd_pend", 32'(rd_pend[k]), exp_pend(ra[k]));
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_sweep = -1;
    end else if (m_sweep >= 0) begin
      m_mem[m_sweep] = '0;
      m_pend[m_sweep] = 1'b0;
      m_sweep++;
      if (m_sweep == DEPTH) m_sweep = -1;
    end else begin
      if (m_wr_acc()) begin
        m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
        m_pend[wr_addr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
      if (clr_start) m_sweep = 0;
    end
  endtask

  task automatic cycle(bit do_chk);
    if (do_chk) begin
      #1;
      check_outputs();
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; pend_set = 1'b0; clr_start = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      ra[0] = AW'(a);
      ra[1] = AW'(DEPTH - 1 - a);
      #1;
      check_outputs();
    end
  endtask

  task automatic write(logic [AW-1:0] a, logic [31:0] d, logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic count_sweep(string tag);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy) nb++;
      cycle(1);
    end
    chk(tag, nb, 32'd32);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    wr_addr = '0; wr_data = '0; wr_be = '0; pend_addr = '0;
    ra[0] = '0; ra[1] = '0;
    cycle(0);
    reset = 1'b0;
    read_all();

    // Byte-enable write and bypass
    write(5, 32'hAABBCCDD, 4'hF);
    cycle(1);
    write(5, 32'h11223344, 4'h5);
    ra[0] = 5;
    #1 chk("bypass_r5", rd_data[31:0], 32'hAA22CC44);
    cycle(1);
    idle_inputs();
    #1 chk("stored_r5", rd_data[31:0], 32'hAA22CC44);
    cycle(1);

    // Zero register
    write(0, 32'hFFFFFFFF, 4'hF);
    pend_set = 1'b1; pend_addr = 0; ra[0] = 0;
    #1 chk("r0_same", rd_data[31:0], 32'h0);
    chk("r0_pend_same", 32'(rd_pend[0]), 32'h0);
    cycle(1);
    idle_inputs();
    #1 chk("r0_next", rd_data[31:0], 32'h0);
    chk("r0_pend_next", 32'(rd_pend[0]), 32'h0);
    cycle(1);

    // Scoreboard
    pend_set = 1'b1; pend_addr = 7;
    cycle(1);
    idle_inputs(); ra[0] = 7;
    #1 chk("pend_r7_set", 32'(rd_pend[0]), 32'h1);
    write(7, 32'h00000077, 4'hF);
    cycle(1);
    idle_inputs();
    #1 chk("pend_r7_clr", 32'(rd_pend[0]), 32'h0);
    write(9, 32'h12345678, 4'hF);
    pend_set = 1'b1; pend_addr = 9;
    cycle(1);
    idle_inputs(); ra[0] = 9;
    #1 chk("r9_data", rd_data[31:0], 32'h12345678);
    chk("r9_pend", 32'(rd_pend[0]), 32'h1);
    cycle(1);

    // Random traffic, occasionally with a sweep in progress
    for (int i = 0; i < 300; i++) begin
      wr_en     = 1'($urandom);
      wr_addr   = AW'($urandom);
      wr_data   = $urandom;
      wr_be     = 4'($urandom);
      pend_set  = ($urandom_range(0, 2) == 0);
      pend_addr = AW'($urandom);
      clr_start = ($urandom_range(0, 79) == 0);
      ra[0]     = (i % 4 == 0) ? wr_addr : AW'($urandom);
      ra[1]     = AW'($urandom);
      cycle(1);
    end
    idle_inputs();
    for (int i = 0; i < 40 && m_sweep >= 0; i++) cycle(1);
    #1 chk("drain", 32'(busy), 32'h0);

    // Bulk clear over a fully populated file
    for (int a = 0; a < DEPTH; a++) begin
      write(AW'(a), 32'(a), 4'hF);
      cycle(1);
    end
    idle_inputs();
    pend_set = 1'b1; pend_addr = 3;
    cycle(1);
    idle_inputs(); ra[0] = 3;
    #1 chk("pend_r3", 32'(rd_pend[0]), 32'h1);
    clr_start = 1'b1;
    cycle(1);
    idle_inputs();
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) write(10, 32'hDEADBEEF, 4'hF);
      else wr_en = 1'b0;
      #1;
      if (i == 4) chk("wr_ready_sweep", 32'(wr_ready), 32'h0);
      if (busy) nb++;
      cycle(1);
    end
    chk("busy_len", nb, 32'd32);
    idle_inputs();
    ra[0] = 10;
    #1 chk("r10_dropped", rd_data[31:0], 32'h0);
    read_all();

    // Reset in the middle of a sweep
    for (int a = 1; a < DEPTH; a++) begin
      write(AW'(a), $urandom, 4'hF);
      pend_set = 1'($urandom); pend_addr = AW'($urandom);
      cycle(1);
    end
    idle_inputs();
    clr_start = 1'b1;
    cycle(1);
    idle_inputs();
    for (int i = 0; i < 11; i++) cycle(1);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    #1 chk("busy_after_rst", 32'(busy), 32'h0);
    chk("wr_ready_after_rst", 32'(wr_ready), 32'h1);
    read_all();
    clr_start = 1'b1;
    cycle(1);
    idle_inputs();
    count_sweep("busy_len_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the CPU datapath, generalising the fixed 32x32 two-read/one-write file. Widths, depth and read-port count are parameters. Adds per-byte write enables, an optional same-cycle write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a sequenced bulk-clear engine that re-zeroes the file one entry per cycle without a global reset.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
- NUM_RD, 2, number of asynchronous read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 is hard-wired to zero
- BYPASS, 1, when 1, a write in flight is forwarded to matching read ports in the same cycle

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  pending bit of each addressed register
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
- wr_ready  out  1  write accepted this cycle; equals !busy
- pend_set  in  1  mark pend_addr pending (producer issued)
- pend_addr  in  ADDR_W  register to mark pending
- clr_start  in  1  start bulk clear
- busy  out  1  bulk clear in progress

## Operation
- Storage: DEPTH x DATA_W flip-flops, plus a DEPTH-bit pending vector and a 2-state FSM (IDLE, CLEAR) with an ADDR_W-bit sweep counter.
- Write: accepted when wr_en && wr_ready. At the clock edge, the entry at wr_addr takes wr_data on enabled bytes; disabled bytes keep their value. The commit also clears pending[wr_addr]. wr_be == 0 changes no data but still clears the pending bit.
- Zero register (ZERO_REG=1):
  - Writes and pend_set to address 0 are discarded.
  - Reads of address 0 return 0 with rd_pend=0.
- Read: purely combinational from stored contents.
- Bypass (BYPASS=1): if an accepted write matches rd_addr[k] (and the address is not a discarded zero-register address), rd_data[k] returns the byte-merged post-write value in the same cycle. rd_pend[k] still reflects the stored bit.
- Scoreboard: pend_set sets pending[pend_addr] at the edge, and is ignored while busy. If pend_set and an accepted write target the same address in the same cycle, set wins and the bit ends at 1.
- Bulk clear FSM:
  - IDLE + clr_start: go to CLEAR with counter = 0.
  - In CLEAR, each cycle zeroes entry[counter] and pending[counter], then increments the counter.
  - When counter == DEPTH-1, the clear of that entry completes and the FSM returns to IDLE.
  - clr_start in CLEAR is ignored.
- Reads during CLEAR are legal and return current contents, partially cleared.

## Timing
- Reset (synchronous, one cycle): all entries 0, pending vector 0, FSM IDLE, counter 0.
- Output values during and right after reset: busy=0, wr_ready=1, rd_data=0, rd_pend=0.
- Reset has priority over every other input, including mid-sweep. A sweep is aborted and everything is zeroed regardless.
- Write latency: visible on the non-bypassed read path the cycle after the edge. Visible on the bypass path in the same cycle.
- busy rises the cycle after clr_start is sampled in IDLE and stays high for exactly DEPTH cycles.
- wr_ready is low for exactly the cycles busy is high. A write presented then is dropped, not queued; the producer must hold it.
- Sweep counter width is ADDR_W. It wraps to 0 only on the return to IDLE, never inside a sweep.

## Test plan
- Reset then read: pulse reset for 1 cycle, then read all 32 addresses on both ports -> rd_data=0 and rd_pend=0 everywhere; busy=0, wr_ready=1.
- Byte-enable write and bypass:
  - Write 0xAABBCCDD to r5 with wr_be=4'b1111.
  - Next cycle, write 0x11223344 to r5 with wr_be=4'b0101, with rd_addr0=5 in the same cycle -> rd_data0=0xAA22CC44 in that cycle.
  - Following cycle -> stored value reads 0xAA22CC44.
- Zero register: write 0xFFFFFFFF to r0 and pend_set r0 -> r0 reads 0, rd_pend=0, in both the same and the next cycle.
- Scoreboard:
  - pend_set r7 -> rd_pend for r7 is 1 the next cycle.
  - Write r7 -> rd_pend for r7 is 0 the next cycle.
  - Same-cycle pend_set r9 plus write r9 -> r9 holds the new data and rd_pend for r9 stays 1.
- Bulk clear:
  - Fill all registers with their index and pend_set r3, then pulse clr_start -> busy high for exactly 32 cycles.
  - A write to r10 on cycle 5 of the sweep is dropped (wr_ready=0).
  - After busy falls, all reads return 0 and all rd_pend are 0.
- Reset mid-sweep: start a clear, assert reset on sweep cycle 12 -> the next cycle shows busy=0, wr_ready=1, all entries 0, and a fresh clr_start starts a full 32-cycle sweep.
